// File: rtl/som_pkg.sv
// Shared definitions for the serial adder/subtractor: state encoding and
// a constant-function clog2 used to size the step counter.
package som_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } som_state_e;

  // Never returns 0 so a single-step configuration still gets a 1-bit counter.
  function automatic int unsigned som_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/som_comp_1bit.sv
// Combinational 1-bit full adder cell.
module som_comp_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/som_serial_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor processing STEP bits per clock,
// LSB first, with a start/busy/done handshake and signed-overflow flag.
module som_serial_nbit
  import som_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] A,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned N  = (STEP == 0) ? 1 : WIDTH / STEP;
  localparam int unsigned CW = som_clog2(N);

  generate
    if (WIDTH < 2 || STEP == 0 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("som_serial_nbit: WIDTH must be >= 2 and divisible by STEP");
    end
  endgenerate

  som_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [STEP:0]         chain;
  logic [STEP-1:0]       sum;
  logic [WIDTH+STEP-1:0] res_cat;
  logic [WIDTH-1:0]      res_next;

  // Operands shift right each step, so the active slice is always the low STEP bits.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < STEP; i++) begin : g_slice
    som_comp_1bit u_cell (
      .a    (x_q[i]),
      .b    (y_q[i]),
      .cin  (chain[i]),
      .s    (sum[i]),
      .cout (chain[i+1])
    );
  end

  assign res_cat  = {sum, res_q};
  assign res_next = res_cat[WIDTH+STEP-1:STEP];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_d     = a_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          x_d     = x;
          y_d     = sub ? ~y : y;
          carry_d = sub ? ~Cin : Cin;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        x_d     = x_q >> STEP;
        y_d     = y_q >> STEP;
        carry_d = chain[STEP];
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        busy_d  = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          a_d     = res_next;
          cout_d  = chain[STEP];
          ovf_d   = chain[STEP] ^ chain[STEP-1];
          cnt_d   = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_q     <= a_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign A    = a_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_som_serial_nbit.sv
// Directed bench for som_serial_nbit in 8/1, 8/8 and 16/4 configurations.
module tb_som_serial_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] a1;
  logic       busyw, donew, coutw, ovfw;
  logic [7:0] aw;

  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] a16;

  int n_vec = 0;
  int n_err = 0;

  som_serial_nbit #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .x(x8), .y(y8), .Cin(cin8),
    .busy(busy1), .done(done1), .A(a1), .Cout(cout1), .ovf(ovf1));

  som_serial_nbit #(.WIDTH(8), .STEP(8)) u_dut8w (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .x(x8), .y(y8), .Cin(cin8),
    .busy(busyw), .done(donew), .A(aw), .Cout(coutw), .ovf(ovfw));

  som_serial_nbit #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .x(x16), .y(y16), .Cin(cin16),
    .busy(busy16), .done(done16), .A(a16), .Cout(cout16), .ovf(ovf16));

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit op on both 8-bit instances; inputs are scrambled after acceptance.
  task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                     input logic ci, input logic sb,
                     input logic [7:0] ea, input logic ec, input logic ev);
    int b1, bw, d1, dw, n1, nw;
    b1 = 0; bw = 0; d1 = -1; dw = -1; n1 = 0; nw = 0;
    @(negedge clk);
    x8 = xa; y8 = ya; cin8 = ci; sub8 = sb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; x8 = ~xa; y8 = ~ya; cin8 = ~ci; sub8 = ~sb;
    for (int c = 0; c < 14; c++) begin
      if (busy1) b1++;
      if (busyw) bw++;
      if (done1) begin n1++; if (d1 < 0) d1 = c; end
      if (donew) begin nw++; if (dw < 0) dw = c; end
      @(negedge clk);
    end
    check({tag, "_lat1"}, d1, 8);
    check({tag, "_busy1"}, b1, 8);
    check({tag, "_ndone1"}, n1, 1);
    check({tag, "_latw"}, dw, 1);
    check({tag, "_busyw"}, bw, 1);
    check({tag, "_A1"}, int'(a1), int'(ea));
    check({tag, "_C1"}, int'(cout1), int'(ec));
    check({tag, "_V1"}, int'(ovf1), int'(ev));
    check({tag, "_Aw"}, int'(aw), int'(ea));
    check({tag, "_Cw"}, int'(coutw), int'(ec));
    check({tag, "_Vw"}, int'(ovfw), int'(ev));
  endtask

  task automatic op16(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                      input logic ci, input logic sb,
                      input logic [15:0] ea, input logic ec, input logic ev);
    int b, d, n;
    b = 0; d = -1; n = 0;
    @(negedge clk);
    x16 = xa; y16 = ya; cin16 = ci; sub16 = sb; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; x16 = ~xa; y16 = ~ya; cin16 = ~ci; sub16 = ~sb;
    for (int c = 0; c < 10; c++) begin
      if (busy16) b++;
      if (done16) begin n++; if (d < 0) d = c; end
      @(negedge clk);
    end
    check({tag, "_lat"}, d, 4);
    check({tag, "_busy"}, b, 4);
    check({tag, "_ndone"}, n, 1);
    check({tag, "_A"}, int'(a16), int'(ea));
    check({tag, "_C"}, int'(cout16), int'(ec));
    check({tag, "_V"}, int'(ovf16), int'(ev));
  endtask

  initial begin
    int d, n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_A", int'(a1), 0);
    check("rst_C", int'(cout1), 0);
    check("rst_V", int'(ovf1), 0);
    check("rst_A16", int'(a16), 0);

    op8("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("addff01c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("add7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub3c1cb", 8'h3C, 8'h1C, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0);

    // start during RUN is ignored by the 8/1 unit; the idle 8/8 unit takes it
    @(negedge clk);
    x8 = 8'h10; y8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    d = -1;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) begin x8 = 8'hAA; y8 = 8'h55; start8 = 1'b1; end
      if (c == 3) start8 = 1'b0;
      if (done1 && d < 0) d = c;
      @(negedge clk);
    end
    check("ign_lat", d, 8);
    check("ign_A1", int'(a1), 8'h30);
    check("ign_Aw", int'(aw), 8'hFF);
    check("ign_Vw", int'(ovfw), 0);

    // reset mid-RUN aborts with no trailing done
    @(negedge clk);
    x8 = 8'h01; y8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(busy1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy1), 0);
    check("abort_done", int'(done1), 0);
    check("abort_A", int'(a1), 0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (done1 || busy1) n++;
      @(negedge clk);
    end
    check("abort_quiet", n, 0);

    op16("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("sub1000", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    op16("add7fff", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1);

    // back-to-back: start held during DONE re-accepts immediately
    @(negedge clk);
    x16 = 16'hFFFF; y16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    d = -1;
    for (int c = 0; c < 14; c++) begin
      if (c == 4) begin
        check("b2b_done1", int'(done16), 1);
        check("b2b_A1", int'(a16), 16'h0000);
        check("b2b_C1", int'(cout16), 1);
        x16 = 16'h1234; y16 = 16'h1111; start16 = 1'b1;
      end
      if (c == 5) begin
        start16 = 1'b0;
        check("b2b_drop", int'(done16), 0);
        check("b2b_busy", int'(busy16), 1);
      end
      if (c == 7) check("b2b_hold", int'(a16), 16'h0000);
      if (c > 4 && done16 && d < 0) d = c;
      @(negedge clk);
    end
    check("b2b_spacing", d - 4, 5);
    check("b2b_A2", int'(a16), 16'h2345);
    check("b2b_C2", int'(cout16), 0);
    check("b2b_V2", int'(ovf16), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
